stack_pointer_unit: RTL and testbench
=====================================

STACK_POINTER_UNIT -- requirements
Module: stack_pointer_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, width of stack pointer and memory address.
REQ-002 SHALL have parameter STACK_BASE, default 8'hFF, SP reset value and empty-stack position.
REQ-003 SHALL have parameter STACK_LIMIT, default 8'h60, lowest address a push may write.
REQ-004 SHALL have parameter CNT_WIDTH, default 2, width of byte-count fields; max op length is 2^CNT_WIDTH-1 bytes.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 op_valid  in  1  operation request.
REQ-009 op_kind  in  2  00 none, 01 PUSH, 10 POP, 11 LOAD_SP.
REQ-010 op_bytes  in  CNT_WIDTH  bytes to push/pop (e.g. 2 for CALL/RET return address).
REQ-011 load_value  in  ADDR_WIDTH  new SP for LOAD_SP.
REQ-012 flag_clear  in  1  clears sticky error flags.
REQ-013 op_ready  out  1  unit idle, request accepted this cycle if op_valid.
REQ-014 sp  out  ADDR_WIDTH  current stack pointer (registered).
REQ-015 mem_en / mem_we  out  1 each  stack memory access strobe / write select.
REQ-016 mem_addr  out  ADDR_WIDTH  stack memory address for current access.
REQ-017 byte_index  out  CNT_WIDTH  index (0-based) of byte being transferred.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 overflow / underflow  out  1 each  sticky error flags.

Function
REQ-020 SHALL use states IDLE, PUSH_SEQ, POP_SEQ; op_ready=1 only in IDLE.
REQ-021 Accept = op_valid && op_ready && op_kind!=00; op_kind=00 SHALL be ignored.
REQ-022 PUSH accepted with op_bytes=N>0 SHALL enter PUSH_SEQ with counter=N, byte_index=0.
REQ-023 Each PUSH_SEQ cycle: mem_en=1, mem_we=1, mem_addr=sp; at the edge sp<=sp-1 (post-decrement), counter decrements, byte_index increments.
REQ-024 POP accepted with N>0 SHALL enter POP_SEQ; each cycle mem_en=1, mem_we=0, mem_addr=sp+1; at the edge sp<=sp+1 (pre-increment).
REQ-025 Sequence SHALL return to IDLE after the edge ending the Nth access; done=1 the following cycle (in IDLE), op_ready also 1, so back-to-back ops lose no cycle.
REQ-026 Latency: N-byte op accepted at edge k performs accesses in cycles k+1..k+N, done in cycle k+N+1.
REQ-027 op_bytes=0 on PUSH/POP SHALL perform no access, leave sp unchanged, stay in IDLE and pulse done next cycle.
REQ-028 LOAD_SP SHALL set sp<=load_value at the accept edge, no memory access, done next cycle.
REQ-029 Overflow: in PUSH_SEQ, if sp < STACK_LIMIT, write SHALL be suppressed (mem_en=0), sp unchanged, overflow<=1, sequence aborts to IDLE, done pulses next cycle.
REQ-030 Underflow: in POP_SEQ, if sp == STACK_BASE, read SHALL be suppressed, sp unchanged, underflow<=1, abort as REQ-029.
REQ-031 Arithmetic SHALL be ADDR_WIDTH modulo; no other wrap checks beyond REQ-029/030.
REQ-032 flag_clear SHALL clear both flags at the edge; a simultaneous new error SHALL win (flag set).
REQ-033 mem_en, mem_we, byte_index SHALL be 0 whenever no access occurs; mem_addr value is don't-care then.

Reset
REQ-034 reset SHALL force state IDLE, sp=STACK_BASE, counter=0, done=0, overflow=0, underflow=0, op_ready=1, mem_en=mem_we=0.
REQ-035 reset mid-sequence SHALL abandon the op with no done pulse and no further access; reset overrides all inputs.

Verification
REQ-036 Reset, PUSH N=2 -> writes at FF then FE (byte_index 0,1), sp=FD, done one cycle after second write.
REQ-037 After REQ-036, POP N=2 -> reads FE then FF, sp=FF, done; then POP N=1 -> underflow=1, no read, sp=FF.
REQ-038 LOAD_SP 8'h60, PUSH N=2 -> write at 60, sp=5F, next byte aborted, overflow=1, done pulses.
REQ-039 Back-to-back: PUSH N=1 held valid with next POP N=1 issued in done cycle -> accesses in consecutive op slots, sp returns to start value.
REQ-040 op_bytes=0 PUSH -> no mem_en, sp unchanged, done next cycle; flag_clear concurrent with new overflow -> overflow stays 1.
REQ-041 reset asserted during second byte of PUSH N=3 -> next cycle sp=FF, IDLE, no done, mem_en=0.

Source files
------------

// File: rtl/stack_pointer_unit.sv
// -----------------------------------------------------------------------------
// stack_pointer_unit
//
// Purpose:
//   This unit holds the stack pointer for a small CPU. It turns PUSH, POP and
//   LOAD_SP requests into a sequence of single-byte stack memory accesses.
//   PUSH writes at sp and then decrements sp, so it is a post-decrement.
//   POP increments sp and then reads at that address, so it is a
//   pre-increment; the read address is sp+1 while the byte is in flight.
//   The unit also keeps sticky overflow and underflow flags.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   op_valid    in   operation request
//   op_kind     in   00 none, 01 PUSH, 10 POP, 11 LOAD_SP
//   op_bytes    in   byte count for PUSH/POP
//   load_value  in   new stack pointer for LOAD_SP
//   flag_clear  in   clears sticky overflow/underflow flags
//   op_ready    out  unit is idle; a request is accepted this cycle if valid
//   sp          out  current stack pointer (registered)
//   mem_en      out  stack memory access strobe
//   mem_we      out  stack memory write select
//   mem_addr    out  stack memory address for the current access
//   byte_index  out  0-based index of the byte being transferred
//   done        out  one-cycle completion pulse
//   overflow    out  sticky: a push tried to write below STACK_LIMIT
//   underflow   out  sticky: a pop tried to read with the stack empty
// -----------------------------------------------------------------------------
module stack_pointer_unit #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE  = 8'hFF,
  parameter logic [ADDR_WIDTH-1:0] STACK_LIMIT = 8'h60,
  parameter int                    CNT_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  input  logic [1:0]            op_kind,
  input  logic [CNT_WIDTH-1:0]  op_bytes,
  input  logic [ADDR_WIDTH-1:0] load_value,
  input  logic                  flag_clear,
  output logic                  op_ready,
  output logic [ADDR_WIDTH-1:0] sp,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [CNT_WIDTH-1:0]  byte_index,
  output logic                  done,
  output logic                  overflow,
  output logic                  underflow
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PUSH_SEQ = 2'd1;
  localparam logic [1:0] POP_SEQ  = 2'd2;

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_PUSH = 2'b01;
  localparam logic [1:0] KIND_POP  = 2'b10;
  localparam logic [1:0] KIND_LOAD = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] SP_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] sp_q, sp_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;     // bytes still to transfer
  logic [CNT_WIDTH-1:0]  idx_q, idx_d;     // index of the current byte
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  // ---------------------------------------------------------------------------
  // Request decode and per-cycle conditions
  // ---------------------------------------------------------------------------
  logic accept;
  logic push_ovf;     // this push byte would write below the limit
  logic pop_unf;      // this pop byte would read from an empty stack
  logic push_access;  // a real write happens this cycle
  logic pop_access;   // a real read happens this cycle
  logic last_byte;

  assign op_ready    = (state_q == IDLE);
  assign accept      = op_valid && op_ready && (op_kind != KIND_NONE);

  assign push_ovf    = (state_q == PUSH_SEQ) && (sp_q < STACK_LIMIT);
  assign pop_unf     = (state_q == POP_SEQ)  && (sp_q == STACK_BASE);
  assign push_access = (state_q == PUSH_SEQ) && !push_ovf;
  assign pop_access  = (state_q == POP_SEQ)  && !pop_unf;
  assign last_byte   = (cnt_q == CNT_ONE);

  // ---------------------------------------------------------------------------
  // Memory interface. The strobes and byte_index are forced to zero whenever
  // no access is made. The address is don't-care then, but it is still driven
  // deterministically.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = sp_q;
    byte_index = '0;
    if (push_access) begin
      mem_en     = 1'b1;
      mem_we     = 1'b1;
      mem_addr   = sp_q;
      byte_index = idx_q;
    end else if (pop_access) begin
      mem_en     = 1'b1;
      mem_we     = 1'b0;
      mem_addr   = sp_q + SP_ONE;      // pre-increment read address
      byte_index = idx_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op_kind)
            KIND_PUSH: begin
              if (op_bytes == '0) begin
                done_d = 1'b1;            // zero-length op: no access at all
              end else begin
                state_d = PUSH_SEQ;
                cnt_d   = op_bytes;
                idx_d   = '0;
              end
            end
            KIND_POP: begin
              if (op_bytes == '0) begin
                done_d = 1'b1;
              end else begin
                state_d = POP_SEQ;
                cnt_d   = op_bytes;
                idx_d   = '0;
              end
            end
            KIND_LOAD: begin
              sp_d   = load_value;
              done_d = 1'b1;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end
      end

      PUSH_SEQ: begin
        if (push_ovf) begin
          // Abort the push and leave sp where it is.
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          sp_d  = sp_q - SP_ONE;
          cnt_d = cnt_q - CNT_ONE;
          idx_d = idx_q + CNT_ONE;
          if (last_byte) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end

      POP_SEQ: begin
        if (pop_unf) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          sp_d  = sp_q + SP_ONE;
          cnt_d = cnt_q - CNT_ONE;
          idx_d = idx_q + CNT_ONE;
          if (last_byte) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sticky flags. The clear is applied first and a new error is applied
  // after it, so an error detected in the same cycle as flag_clear stays set.
  // ---------------------------------------------------------------------------
  always_comb begin
    ovf_d = flag_clear ? 1'b0 : ovf_q;
    unf_d = flag_clear ? 1'b0 : unf_q;
    if (push_ovf) ovf_d = 1'b1;
    if (pop_unf)  unf_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sp_q    <= STACK_BASE;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign sp        = sp_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_pointer_unit
//
// Directed self-checking bench for stack_pointer_unit (default parameters).
// Inputs change 1 time unit after the rising edge. Outputs are sampled at
// that same point, when the registered state of the cycle has settled.
// -----------------------------------------------------------------------------
module tb_stack_pointer_unit;

  logic       clk;
  logic       reset;
  logic       op_valid;
  logic [1:0] op_kind;
  logic [1:0] op_bytes;
  logic [7:0] load_value;
  logic       flag_clear;
  logic       op_ready;
  logic [7:0] sp;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [1:0] byte_index;
  logic       done;
  logic       overflow;
  logic       underflow;

  int checks;
  int errors;

  stack_pointer_unit dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_kind    (op_kind),
    .op_bytes   (op_bytes),
    .load_value (load_value),
    .flag_clear (flag_clear),
    .op_ready   (op_ready),
    .sp         (sp),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .byte_index (byte_index),
    .done       (done),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] kind, input logic [1:0] n, input logic [7:0] lv);
    op_valid   = 1'b1;
    op_kind    = kind;
    op_bytes   = n;
    load_value = lv;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (sp !== 8'hFF) begin errors++; $display("FAIL reset_sp got %h exp ff", sp); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", op_ready); end
    checks++; if ({mem_en, mem_we, done, overflow, underflow} !== 5'b0) begin errors++;
      $display("FAIL reset_outs got %b exp 00000", {mem_en, mem_we, done, overflow, underflow}); end
    $display("txn reset sp=%h", sp);
  endtask

  task automatic test_push2();
    issue(2'b01, 2'd2, 8'h00);
    step();
    op_valid = 1'b0;
    checks++; if ({mem_en, mem_we, mem_addr, byte_index, op_ready, done} !== {2'b11, 8'hFF, 2'd0, 2'b00}) begin errors++;
      $display("FAIL push2_b0 got en%b we%b a%h i%0d r%b d%b exp en1 we1 aff i0 r0 d0", mem_en, mem_we, mem_addr, byte_index, op_ready, done); end
    step();
    checks++; if ({mem_en, mem_we, mem_addr, byte_index, done} !== {2'b11, 8'hFE, 2'd1, 1'b0}) begin errors++;
      $display("FAIL push2_b1 got en%b we%b a%h i%0d d%b exp en1 we1 afe i1 d0", mem_en, mem_we, mem_addr, byte_index, done); end
    step();
    checks++; if ({done, op_ready, mem_en, byte_index, sp} !== {3'b110, 2'd0, 8'hFD}) begin errors++;
      $display("FAIL push2_done got d%b r%b en%b i%0d sp%h exp d1 r1 en0 i0 spfd", done, op_ready, mem_en, byte_index, sp); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL push2_pulse got %b exp 0", done); end
    $display("txn push2 sp=%h", sp);
  endtask

  task automatic test_pop_underflow();
    issue(2'b10, 2'd2, 8'h00);
    step();
    op_valid = 1'b0;
    checks++; if ({mem_en, mem_we, mem_addr, byte_index} !== {2'b10, 8'hFE, 2'd0}) begin errors++;
      $display("FAIL pop2_b0 got en%b we%b a%h i%0d exp en1 we0 afe i0", mem_en, mem_we, mem_addr, byte_index); end
    step();
    checks++; if ({mem_en, mem_we, mem_addr, byte_index} !== {2'b10, 8'hFF, 2'd1}) begin errors++;
      $display("FAIL pop2_b1 got en%b we%b a%h i%0d exp en1 we0 aff i1", mem_en, mem_we, mem_addr, byte_index); end
    step();
    checks++; if ({done, sp, underflow} !== {1'b1, 8'hFF, 1'b0}) begin errors++;
      $display("FAIL pop2_done got d%b sp%h u%b exp d1 spff u0", done, sp, underflow); end
    $display("txn pop2 sp=%h", sp);
    issue(2'b10, 2'd1, 8'h00);
    step();
    op_valid = 1'b0;
    checks++; if ({mem_en, op_ready} !== 2'b00) begin errors++;
      $display("FAIL pop_unf_access got en%b r%b exp en0 r0", mem_en, op_ready); end
    step();
    checks++; if ({underflow, done, sp, mem_en} !== {2'b11, 8'hFF, 1'b0}) begin errors++;
      $display("FAIL pop_unf_flag got u%b d%b sp%h en%b exp u1 d1 spff en0", underflow, done, sp, mem_en); end
    $display("txn pop1_underflow sp=%h", sp);
  endtask

  task automatic test_overflow();
    issue(2'b11, 2'd0, 8'h60);
    step();
    checks++; if ({done, sp, mem_en} !== {1'b1, 8'h60, 1'b0}) begin errors++;
      $display("FAIL load_sp got d%b sp%h en%b exp d1 sp60 en0", done, sp, mem_en); end
    issue(2'b01, 2'd2, 8'h00);
    step();
    op_valid = 1'b0;
    checks++; if ({mem_en, mem_we, mem_addr, byte_index} !== {2'b11, 8'h60, 2'd0}) begin errors++;
      $display("FAIL ovf_b0 got en%b we%b a%h i%0d exp en1 we1 a60 i0", mem_en, mem_we, mem_addr, byte_index); end
    step();
    checks++; if ({mem_en, mem_we, byte_index, sp} !== {2'b00, 2'd0, 8'h5F}) begin errors++;
      $display("FAIL ovf_b1 got en%b we%b i%0d sp%h exp en0 we0 i0 sp5f", mem_en, mem_we, byte_index, sp); end
    step();
    checks++; if ({overflow, done, sp, op_ready} !== {2'b11, 8'h5F, 1'b1}) begin errors++;
      $display("FAIL ovf_flag got o%b d%b sp%h r%b exp o1 d1 sp5f r1", overflow, done, sp, op_ready); end
    $display("txn push2_overflow sp=%h", sp);
  endtask

  task automatic test_zero_and_clear();
    flag_clear = 1'b1;
    step();
    flag_clear = 1'b0;
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++;
      $display("FAIL flag_clear got o%b u%b exp o0 u0", overflow, underflow); end
    issue(2'b01, 2'd0, 8'h00);
    step();
    op_valid = 1'b0;
    checks++; if ({done, mem_en, op_ready, sp} !== {3'b101, 8'h5F}) begin errors++;
      $display("FAIL zero_push got d%b en%b r%b sp%h exp d1 en0 r1 sp5f", done, mem_en, op_ready, sp); end
    $display("txn push0 sp=%h", sp);
    // sp = 5F is below the limit, so this push overflows while the clear is held.
    issue(2'b01, 2'd1, 8'h00);
    step();
    op_valid   = 1'b0;
    flag_clear = 1'b1;
    step();
    flag_clear = 1'b0;
    checks++; if ({overflow, done, sp} !== {2'b11, 8'h5F}) begin errors++;
      $display("FAIL clear_vs_ovf got o%b d%b sp%h exp o1 d1 sp5f", overflow, done, sp); end
    $display("txn push1_overflow_with_clear ovf=%b", overflow);
  endtask

  task automatic test_back_to_back();
    issue(2'b11, 2'd0, 8'h80);
    step();
    issue(2'b01, 2'd1, 8'h00);
    step();
    checks++; if ({mem_en, mem_we, mem_addr} !== {2'b11, 8'h80}) begin errors++;
      $display("FAIL b2b_push got en%b we%b a%h exp en1 we1 a80", mem_en, mem_we, mem_addr); end
    issue(2'b10, 2'd1, 8'h00);   // presented while busy, taken in the done cycle
    step();
    checks++; if ({done, op_ready, sp} !== {2'b11, 8'h7F}) begin errors++;
      $display("FAIL b2b_done1 got d%b r%b sp%h exp d1 r1 sp7f", done, op_ready, sp); end
    step();
    op_valid = 1'b0;
    checks++; if ({mem_en, mem_we, mem_addr, done} !== {2'b10, 8'h80, 1'b0}) begin errors++;
      $display("FAIL b2b_pop got en%b we%b a%h d%b exp en1 we0 a80 d0", mem_en, mem_we, mem_addr, done); end
    step();
    checks++; if ({done, sp} !== {1'b1, 8'h80}) begin errors++;
      $display("FAIL b2b_done2 got d%b sp%h exp d1 sp80", done, sp); end
    $display("txn back_to_back sp=%h", sp);
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    step();
    reset = 1'b0;
    issue(2'b01, 2'd3, 8'h00);
    step();
    op_valid = 1'b0;
    checks++; if ({mem_en, mem_addr} !== {1'b1, 8'hFF}) begin errors++;
      $display("FAIL rst_mid_b0 got en%b a%h exp en1 aff", mem_en, mem_addr); end
    step();
    checks++; if ({mem_en, mem_addr, byte_index} !== {1'b1, 8'hFE, 2'd1}) begin errors++;
      $display("FAIL rst_mid_b1 got en%b a%h i%0d exp en1 afe i1", mem_en, mem_addr, byte_index); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if ({sp, op_ready, done, mem_en} !== {8'hFF, 3'b100}) begin errors++;
      $display("FAIL rst_mid_state got sp%h r%b d%b en%b exp spff r1 d0 en0", sp, op_ready, done, mem_en); end
    step();
    checks++; if ({done, mem_en, sp} !== {2'b00, 8'hFF}) begin errors++;
      $display("FAIL rst_mid_after got d%b en%b sp%h exp d0 en0 spff", done, mem_en, sp); end
    $display("txn reset_mid_push sp=%h", sp);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    op_valid   = 1'b0;
    op_kind    = 2'b00;
    op_bytes   = 2'd0;
    load_value = 8'h00;
    flag_clear = 1'b0;
    test_reset();
    test_push2();
    test_pop_underflow();
    test_overflow();
    test_zero_and_clear();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
